// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG capture controller.
package trng_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_SAMPLE_GAP    = 16;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_REP_LIMIT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } trng_ctrl_state_t;

endpackage

// File: rtl/trng_ctrl_fifo.sv
// sync_fifo: generic single-clock FIFO with a registered head word (rd output q).
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [AW-1:0]    w_rd_ptr_next;
  logic [CW-1:0]    w_count_next;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign w_rd_ptr_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  // The head register forwards the incoming word when it lands in the next head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q      <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_count_next != '0) begin
        r_q <= (w_push && (w_rd_ptr_next == r_wr_ptr)) ? data : r_mem[w_rd_ptr_next];
      end
    end
  end

  assign q     = r_q;
  assign count = r_count;

endmodule

// File: rtl/trng_ctrl.sv
// TRNG capture controller: warmup, periodic sampling, repetition health test, output FIFO.
// Optional build macro TRNG_CTRL_WHITEN_EN pushes capture XOR previous capture instead of raw.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter  int SAMPLE_GAP    = DEF_SAMPLE_GAP,
  parameter  int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter  int REP_LIMIT     = DEF_REP_LIMIT,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  health_fail,
  output logic                  busy,
  output logic [CW-1:0]         count
);

  localparam int CNT_MAX = (WARMUP_CYCLES > SAMPLE_GAP) ? WARMUP_CYCLES : SAMPLE_GAP;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(REP_LIMIT + 1);

  trng_ctrl_state_t r_state, w_state_next;
  logic [TW-1:0]         r_timer, w_timer_next;
  logic [RW-1:0]         r_rep, w_rep_next;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic                  r_has_prev;
  logic                  r_cap_valid;
  logic                  w_capture;
  logic                  w_rep_hit;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  assign w_rep_next = (r_has_prev && (raw == r_prev)) ? r_rep + 1'b1 : '0;
  assign w_rep_hit  = (w_rep_next == RW'(REP_LIMIT - 1));

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer + 1'b1;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (enable) w_state_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (r_timer == TW'(WARMUP_CYCLES - 1)) begin
          w_state_next = ST_RUN;
          w_timer_next = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_next = ST_IDLE;
        end else if (r_timer == TW'(SAMPLE_GAP - 1)) begin
          w_capture    = 1'b1;
          w_timer_next = '0;
          if (w_rep_hit) w_state_next = ST_FAIL;
        end
      end
      ST_FAIL: begin
        w_timer_next = '0;
        if (!enable) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_rep       <= '0;
      r_prev      <= '0;
      r_has_prev  <= 1'b0;
      r_cap_data  <= '0;
      r_cap_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_cap_valid <= 1'b0;
      // A fresh enable starts the repetition history from scratch.
      if (r_state == ST_IDLE) begin
        r_has_prev <= 1'b0;
        r_rep      <= '0;
      end
      if (w_capture) begin
        r_prev     <= raw;
        r_has_prev <= 1'b1;
        r_rep      <= w_rep_next;
`ifdef TRNG_CTRL_WHITEN_EN
        r_cap_data  <= raw ^ r_prev;
        r_cap_valid <= r_has_prev && !w_rep_hit;
`else
        r_cap_data  <= raw;
        r_cap_valid <= !w_rep_hit;
`endif
      end
    end
  end

  assign w_pop  = rd_valid && rd_ready;
  assign w_push = r_cap_valid && (!w_full || w_pop);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .data  (r_cap_data),
    .q     (rd_data),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  assign rd_valid    = !w_empty;
  assign health_fail = (r_state == ST_FAIL);
  assign busy        = (r_state == ST_WARMUP) || (r_state == ST_RUN);

endmodule

// File: tb/tb_trng_ctrl.sv
// Randomized bench for trng_ctrl against a queue-based reference model (either whitening build).
`timescale 1ns/1ps
module tb_trng_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int WARM  = 64;
  localparam int REP   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef TRNG_CTRL_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] raw = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          health_fail;
  logic          busy;
  logic [CW-1:0] count;

  trng_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .raw         (raw),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .health_fail (health_fail),
    .busy        (busy),
    .count       (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode, edges spent in mode, FIFO as a queue, pending captured word.
  typedef enum {M_IDLE, M_WARM, M_RUN, M_FAIL} mmode_t;
  mmode_t        m_mode = M_IDLE;
  int            m_edges = 0;
  logic [DW-1:0] m_q[$];
  bit            m_pend = 0;
  logic [DW-1:0] m_pend_word = '0;
  logic [DW-1:0] m_prev = '0;
  bit            m_has_prev = 0;
  int            m_rep = 0;
  int            m_caps = 0;
  int            edge_no = 0;
  logic [DW-1:0] first_word = '0;

  task automatic model_capture();
    m_caps++;
    if (m_has_prev && raw == m_prev) m_rep++;
    else m_rep = 0;
    if (m_rep == REP - 1) m_mode = M_FAIL;
    else if (!WHITEN) begin
      m_pend = 1; m_pend_word = raw;
    end else if (m_has_prev) begin
      m_pend = 1; m_pend_word = raw ^ m_prev;
    end
    m_prev = raw;
    m_has_prev = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    if (rst) begin
      m_mode = M_IDLE; m_edges = 0; m_q.delete(); m_pend = 0;
      m_has_prev = 0; m_rep = 0; m_prev = '0;
    end else begin
      if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
      if (m_pend && m_q.size() < DEPTH) m_q.push_back(m_pend_word);
      m_pend = 0;
      case (m_mode)
        M_IDLE: if (enable) begin
          m_mode = M_WARM; m_edges = 0; m_has_prev = 0; m_rep = 0;
        end
        M_WARM: if (!enable) m_mode = M_IDLE;
          else begin
            m_edges++;
            if (m_edges == WARM) begin m_mode = M_RUN; m_edges = 0; end
          end
        M_RUN: if (!enable) m_mode = M_IDLE;
          else begin
            m_edges++;
            if (m_edges % GAP == 0) model_capture();
          end
        M_FAIL: if (!enable) m_mode = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health got=%b want=0", health_fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    rst = 0; tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_warmup();
    logic [DW-1:0] raws[101];
    int first = -1;
    int exp_first;
    logic [DW-1:0] word = '0;
    logic [DW-1:0] exp_word;
    exp_first = WHITEN ? WARM + 2*GAP + 1 : WARM + GAP + 1;
    rd_ready = 0; enable = 1; raw = $urandom; tick();
    for (int i = 1; i <= 100; i++) begin
      raw = $urandom; raws[i] = raw;
      tick();
      total++; if (rd_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL warmup_valid cyc=%0d got=%b want=%b", i, rd_valid, m_q.size() != 0); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL warmup_busy cyc=%0d got=%b want=1", i, busy); end
      total++; if (count !== CW'(m_q.size())) begin bad++; $display("FAIL warmup_count cyc=%0d got=%0d want=%0d", i, count, m_q.size()); end
      if (rd_valid === 1'b1 && first < 0) begin first = i; word = rd_data; end
    end
    exp_word = WHITEN ? (raws[WARM + 2*GAP] ^ raws[WARM + GAP]) : raws[WARM + GAP];
    total++; if (first != exp_first) begin bad++; $display("FAIL warmup_first_valid got=%0d want=%0d", first, exp_first); end
    total++; if (word !== exp_word) begin bad++; $display("FAIL warmup_first_word got=%h want=%h", word, exp_word); end
    first_word = exp_word;
    $display("warmup: first word %h at cycle %0d", word, first);
  endtask

  task automatic test_full_drop();
    int n = 0;
    rd_ready = 0;
    while (m_caps < 6 || m_pend) begin
      raw = $urandom; tick(); n++;
      total++; if (count !== CW'(m_q.size())) begin bad++; $display("FAIL drop_count got=%0d want=%0d", count, m_q.size()); end
      if (n > 300) break;
    end
    total++; if (n > 300) begin bad++; $display("FAIL drop_timeout got=%0d want<=300", n); end
    total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL drop_full got=%0d want=%0d", count, DEPTH); end
    total++; if (rd_data !== first_word) begin bad++; $display("FAIL drop_head got=%h want=%h", rd_data, first_word); end
    $display("full_drop: count=%0d head=%h", count, rd_data);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_head;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      rd_ready = 0;
      while (!m_pend && n < 40) begin raw = $urandom; tick(); n++; end
      total++; if (!m_pend) begin bad++; $display("FAIL b2b_timeout got=%0d want<40", n); end
      exp_head = m_q[1];
      rd_ready = 1; raw = $urandom; tick(); rd_ready = 0;
      total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", count, DEPTH); end
      total++; if (rd_data !== exp_head) begin bad++; $display("FAIL b2b_order got=%h want=%h", rd_data, exp_head); end
      total++; if (m_q.size() > 0 && m_q[m_q.size()-1] !== m_pend_word) begin bad++; $display("FAIL b2b_tail got=%h want=%h", m_q[m_q.size()-1], m_pend_word); end
      $display("push_pop_full: head now %h count=%0d", rd_data, count);
    end
  endtask

  task automatic test_health();
    int n = 0;
    rd_ready = 0; raw = 32'hDEADBEEF;
    while (m_mode != M_FAIL && n < 200) begin
      tick(); n++;
      total++; if (health_fail !== (m_mode == M_FAIL)) begin bad++; $display("FAIL health_flag got=%b want=%b", health_fail, m_mode == M_FAIL); end
    end
    total++; if (m_mode != M_FAIL) begin bad++; $display("FAIL health_timeout got=%0d want<200", n); end
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_set got=%b want=1", health_fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL health_busy got=%b want=0", busy); end
    for (int i = 0; i < 60; i++) begin
      rd_ready = (i >= 50) ? 1'b1 : 1'(($urandom_range(0, 1)));
      if (rd_valid && rd_ready) $display("drain: pop %h", rd_data);
      tick();
      total++; if (count !== CW'(m_q.size())) begin bad++; $display("FAIL drain_count got=%0d want=%0d", count, m_q.size()); end
      if (m_q.size() > 0) begin
        total++; if (rd_data !== m_q[0]) begin bad++; $display("FAIL drain_data got=%h want=%h", rd_data, m_q[0]); end
      end
    end
    total++; if (count !== '0) begin bad++; $display("FAIL drain_empty got=%0d want=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", rd_valid); end
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_sticky got=%b want=1", health_fail); end
    rd_ready = 0;
  endtask

  task automatic test_clear();
    int first = -1;
    int exp_first;
    exp_first = WHITEN ? WARM + 2*GAP + 1 : WARM + GAP + 1;
    enable = 0; tick();
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL clear_health got=%b want=0", health_fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", busy); end
    tick();
    enable = 1; rd_ready = 1; raw = $urandom; tick();
    for (int i = 1; i <= 100; i++) begin
      raw = $urandom; tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rewarm_busy cyc=%0d got=%b want=1", i, busy); end
      total++; if (rd_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rewarm_valid cyc=%0d got=%b want=%b", i, rd_valid, m_q.size() != 0); end
      if (rd_valid === 1'b1 && first < 0) first = i;
    end
    total++; if (first != exp_first) begin bad++; $display("FAIL rewarm_first got=%0d want=%0d", first, exp_first); end
    $display("clear: rewarm first word at cycle %0d", first);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    rd_ready = 0;
    while (m_q.size() != 3 && n < 300) begin raw = $urandom; tick(); n++; end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL midrst_pre_count got=%0d want=3", count); end
    rst = 1; tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", rd_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL midrst_health got=%b want=0", health_fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (count !== '0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (count !== '0) begin bad++; $display("FAIL postrst_count got=%0d want=0", count); end
      total++; if (busy !== (m_mode == M_WARM || m_mode == M_RUN)) begin bad++; $display("FAIL postrst_busy got=%b want=%b", busy, m_mode == M_WARM || m_mode == M_RUN); end
    end
    $display("mid_reset: cleared after %0d wait cycles", n);
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_full_drop();
    test_back_to_back();
    test_health();
    test_clear();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
